// File: rtl/decoder_mac_sched.sv
// Dot-product MAC job scheduler with ap_ctrl-style start/ready/done and operand/result handshakes.
// Optional build macro DECODER_MAC_SAT_EN: saturate dout instead of wrapping to OUT_WIDTH.
module decoder_mac_sched #(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 4
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 ap_start,
  input  logic [7:0]           len,
  output logic                 ap_idle,
  output logic                 ap_ready,
  output logic                 ap_done,
  input  logic [15:0]          din_a,
  input  logic [5:0]           din_b,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready
);

  localparam int unsigned PROD_WIDTH = 22;

`ifdef DECODER_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(64'sd1 <<< (OUT_WIDTH - 1)));
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t                         state, state_nx;
  logic [7:0]                     len_r, cnt;
  logic signed [PROD_WIDTH-1:0]   prod_r, prod_c;
  logic                           prod_v;
  logic signed [ACC_WIDTH-1:0]    acc, acc_nx, shifted_c;
  logic [OUT_WIDTH-1:0]           res_c;
  logic                           start_c, beat_c, done_c;

  assign prod_c = PROD_WIDTH'($signed(din_a)) * PROD_WIDTH'($signed(din_b));

  // State register
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and job events
  always_comb begin
    state_nx = state;
    start_c  = 1'b0;
    beat_c   = 1'b0;
    done_c   = 1'b0;
    case (state)
      IDLE: begin
        if (ap_start) begin
          start_c  = 1'b1;
          state_nx = (len == 8'd0) ? OUT : RUN;
        end
      end
      RUN: begin
        if (din_valid && din_ready) begin
          beat_c = 1'b1;
          if (cnt == len_r - 8'd1) state_nx = DRAIN;
        end
      end
      DRAIN: state_nx = OUT;
      OUT: begin
        if (dout_ready) begin
          done_c   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Accumulate one cycle behind product capture; result reduction to OUT_WIDTH
  always_comb begin
    acc_nx = acc;
    if (start_c)     acc_nx = '0;
    else if (prod_v) acc_nx = acc + ACC_WIDTH'(prod_r);
    shifted_c = acc_nx >>> SHIFT;
`ifdef DECODER_MAC_SAT_EN
    if (shifted_c > SAT_MAX)      res_c = OUT_WIDTH'(SAT_MAX);
    else if (shifted_c < SAT_MIN) res_c = OUT_WIDTH'(SAT_MIN);
    else                          res_c = OUT_WIDTH'(shifted_c);
`else
    res_c = OUT_WIDTH'(shifted_c);
`endif
  end

  // Datapath and registered outputs
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      len_r      <= '0;
      cnt        <= '0;
      prod_r     <= '0;
      prod_v     <= 1'b0;
      acc        <= '0;
      dout       <= '0;
      ap_idle    <= 1'b1;
      ap_ready   <= 1'b0;
      ap_done    <= 1'b0;
      din_ready  <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      acc    <= acc_nx;
      prod_v <= beat_c;
      if (beat_c) prod_r <= prod_c;
      if (start_c) begin
        len_r <= len;
        cnt   <= '0;
      end else if (beat_c) begin
        cnt <= cnt + 8'd1;
      end
      // dout is captured once on OUT entry and then held until the handshake
      if (state_nx == OUT && state != OUT) dout <= res_c;
      ap_idle    <= (state_nx == IDLE);
      din_ready  <= (state_nx == RUN);
      dout_valid <= (state_nx == OUT);
      ap_ready   <= start_c;
      ap_done    <= done_c;
    end
  end

endmodule

// File: tb/tb_decoder_mac_sched.sv
// Randomized self-checking bench for decoder_mac_sched; SHIFT=0 and SHIFT=4 instances share stimulus.
module tb_decoder_mac_sched;

  logic        clk = 1'b0;
  logic        ap_rst, ap_start, din_valid, dout_ready;
  logic [7:0]  len;
  logic [15:0] din_a;
  logic [5:0]  din_b;

  logic        idle0, ready0, done0, dr0, dv0;
  logic        idle4, ready4, done4, dr4, dv4;
  logic [15:0] dout0, dout4;

  int n_cmp = 0;
  int n_err = 0;
  int n_ready = 0;
  int n_done = 0;
  int ja [0:255];
  int jb [0:255];
  bit keep_start = 1'b0;

  always #5 clk = ~clk;

  decoder_mac_sched #(.ACC_WIDTH(32), .OUT_WIDTH(16), .SHIFT(0)) dut0 (
    .ap_clk(clk), .ap_rst(ap_rst), .ap_start(ap_start), .len(len),
    .ap_idle(idle0), .ap_ready(ready0), .ap_done(done0),
    .din_a(din_a), .din_b(din_b), .din_valid(din_valid), .din_ready(dr0),
    .dout(dout0), .dout_valid(dv0), .dout_ready(dout_ready)
  );

  decoder_mac_sched #(.ACC_WIDTH(32), .OUT_WIDTH(16), .SHIFT(4)) dut4 (
    .ap_clk(clk), .ap_rst(ap_rst), .ap_start(ap_start), .len(len),
    .ap_idle(idle4), .ap_ready(ready4), .ap_done(done4),
    .din_a(din_a), .din_b(din_b), .din_valid(din_valid), .din_ready(dr4),
    .dout(dout4), .dout_valid(dv4), .dout_ready(dout_ready)
  );

  always @(negedge clk) begin
    if (ready0) n_ready++;
    if (done0)  n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact sum wrapped to 32 bits, arithmetic shift, then wrap or saturate to 16 bits
  function automatic logic [15:0] model(input longint s, input int sh);
    logic signed [31:0] w;
    longint v;
    w = 32'(s);
    w = w >>> sh;
    v = longint'(w);
`ifdef DECODER_MAC_SAT_EN
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
`endif
    return 16'(v);
  endfunction

  task automatic run_job(input int n, input int gap, input int hold);
    longint sum;
    logic [15:0] e0, e4;
    int got, budget, r0;
    bit ok;
    sum = 0;
    for (int i = 0; i < n; i++) sum += longint'(ja[i]) * longint'(jb[i]);
    e0 = model(sum, 0);
    e4 = model(sum, 4);
    r0 = n_ready;
    chk("idle_before", 32'(idle0), 1);
    ap_start = 1'b1;
    len = 8'(n);
    step();
    if (!keep_start) ap_start = 1'b0;
    len = 8'($urandom);
    chk("ap_ready", 32'(ready0), 1);
    chk("idle_busy", 32'(idle0), 0);
    if (n == 0) begin
      chk("len0_dout_valid", 32'(dv0), 1);
      chk("len0_no_din_ready", 32'(dr0), 0);
    end else begin
      got = 0;
      budget = 0;
      chk("din_ready_run", 32'(dr0), 1);
      while (got < n && budget < 1000) begin
        if (gap == 0)      din_valid = 1'b1;
        else if (gap == 1) din_valid = 1'(budget % 2);
        else               din_valid = ($urandom_range(3) != 0);
        din_a = din_valid ? 16'(ja[got]) : 16'($urandom);
        din_b = din_valid ? 6'(jb[got])  : 6'($urandom);
        ok = din_valid && dr0;
        step();
        budget++;
        if (ok) got++;
      end
      din_valid = 1'b0;
      din_a = 16'($urandom);
      din_b = 6'($urandom);
      chk("beats_taken", 32'(got), 32'(n));
      chk("drain_no_valid", 32'(dv0), 0);
      chk("drain_no_din_ready", 32'(dr0), 0);
      step();
      chk("out_valid", 32'(dv0), 1);
    end
    for (int h = 0; h < hold; h++) begin
      chk("dout0_hold", 32'(dout0), 32'(e0));
      chk("dout4_hold", 32'(dout4), 32'(e4));
      chk("valid_hold", 32'(dv0), 1);
      step();
    end
    chk("dout0", 32'(dout0), 32'(e0));
    chk("dout4", 32'(dout4), 32'(e4));
    chk("dout_valid4", 32'(dv4), 1);
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    chk("ap_done", 32'(done0), 1);
    chk("ap_done4", 32'(done4), 1);
    chk("valid_clear", 32'(dv0), 0);
    chk("idle_after", 32'(idle0), 1);
    if (!keep_start) begin
      step();
      chk("ap_done_one_cycle", 32'(done0), 0);
    end
    chk("one_ready_per_job", 32'(n_ready - r0), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_idle"},   32'(idle0), 1);
    chk({tag, "_ready"},  32'(ready0), 0);
    chk({tag, "_done"},   32'(done0), 0);
    chk({tag, "_dinrdy"}, 32'(dr0), 0);
    chk({tag, "_dvalid"}, 32'(dv0), 0);
    chk({tag, "_dout0"},  32'(dout0), 0);
    chk({tag, "_dout4"},  32'(dout4), 0);
    chk({tag, "_idle4"},  32'(idle4), 1);
  endtask

  initial begin
    int d0;
    ap_rst = 1'b1;
    ap_start = 1'b0;
    len = '0;
    din_a = '0;
    din_b = '0;
    din_valid = 1'b0;
    dout_ready = 1'b0;
    #1;
    chk_reset_outputs("por");
    repeat (3) step();
    ap_rst = 1'b0;
    step();

    // (100,2),(-50,3),(7,-1) -> 43
    ja[0] = 100; jb[0] = 2;
    ja[1] = -50; jb[1] = 3;
    ja[2] = 7;   jb[2] = -1;
    run_job(3, 0, 0);

    // Zero-length job
    run_job(0, 0, 2);

    // Alternating gaps, result back-pressure for 5 cycles
    for (int i = 0; i < 4; i++) begin
      ja[i] = int'($urandom_range(65535)) - 32768;
      jb[i] = int'($urandom_range(63)) - 32;
    end
    run_job(4, 1, 5);

    // Large positive sum: wraps or saturates at 16 bits
    ja[0] = 32767; jb[0] = 31;
    ja[1] = 32767; jb[1] = 31;
    run_job(2, 0, 1);

    // Reset after 2 of 5 beats discards the job
    for (int i = 0; i < 5; i++) begin
      ja[i] = 1000 + i;
      jb[i] = 5;
    end
    ap_start = 1'b1;
    len = 8'd5;
    step();
    ap_start = 1'b0;
    din_valid = 1'b1;
    din_a = 16'(ja[0]); din_b = 6'(jb[0]);
    step();
    din_a = 16'(ja[1]); din_b = 6'(jb[1]);
    step();
    din_a = 16'(ja[2]);
    ap_rst = 1'b1;
    #1;
    chk_reset_outputs("midjob_rst");
    d0 = n_done;
    step();
    step();
    ap_rst = 1'b0;
    din_valid = 1'b0;
    repeat (3) step();
    chk("no_done_after_rst", 32'(n_done - d0), 0);
    chk("idle_after_rst", 32'(idle0), 1);
    ja[0] = 3; jb[0] = 3;
    run_job(1, 0, 0);

    // ap_start held high across two jobs
    keep_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ja[i] = 10 * (i + 1);
      jb[i] = -(i + 2);
    end
    run_job(3, 2, 1);
    ja[0] = -32768; jb[0] = -32;
    ja[1] = 1234;   jb[1] = 17;
    run_job(2, 0, 0);
    ap_start = 1'b0;
    keep_start = 1'b0;
    step();
    chk("held_start_done_pulse", 32'(done0), 0);
    chk("held_start_idle", 32'(idle0), 1);
    chk("held_start_no_extra_ready", 32'(ready0), 0);

    // Randomized jobs
    for (int j = 0; j < 30; j++) begin
      int n;
      n = (j % 7 == 6) ? int'($urandom_range(40)) : int'($urandom_range(12));
      for (int i = 0; i < n; i++) begin
        ja[i] = int'($urandom_range(65535)) - 32768;
        jb[i] = int'($urandom_range(63)) - 32;
      end
      run_job(n, int'($urandom_range(2)), int'($urandom_range(3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
